// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with start/abort control and a one-cycle done strobe.
// Counts from a loaded value to zero, one step every prescale+1 clocks, optionally auto-reloading.
module countdown_timer #(
  parameter int unsigned N  = 7,
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          asyncReset,
  input  logic [N-1:0]  load_value_i,
  input  logic [PW-1:0] prescale_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          auto_reload_i,
  output logic [N-1:0]  q_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [PW-1:0] PreOne = PW'(1);
  localparam logic [N-1:0]  QOne   = N'(1);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  // Prescale value captured at start/reload; mid-run changes on prescale_i are ignored.
  logic [PW-1:0] presc_q, presc_d;
  logic [N-1:0]  q_q, q_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    presc_d = presc_q;
    q_d     = q_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!abort_i && start_i) begin
          q_d     = load_value_i;
          pre_d   = prescale_i;
          presc_d = prescale_i;
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort_i) begin
          q_d     = '0;
          pre_d   = '0;
          state_d = StIdle;
        end else if (pre_q != '0) begin
          pre_d = pre_q - PreOne;
        end else if (q_q != '0) begin
          q_d   = q_q - QOne;
          pre_d = presc_q;
        end else begin
          // Terminal tick: q is already zero, so a non-reloading run leaves q at 0.
          done_d = 1'b1;
          if (auto_reload_i) begin
            q_d     = load_value_i;
            pre_d   = prescale_i;
            presc_d = prescale_i;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge asyncReset) begin
    if (asyncReset) begin
      state_q <= StIdle;
      pre_q   <= '0;
      presc_q <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      presc_q <= presc_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign q_o    = q_q;
  assign busy_o = (state_q == StRun);
  assign done_o = done_q;

endmodule
